// File: rtl/tpu_ctrl_pkg.sv
// Shared control definitions for the TPU sequencing logic: FSM state encoding
// and the default datapath latency derived from the systolic array size.
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT_W = 3'd1,
        S_LOAD_W = 3'd2,
        S_RELOAD = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int unsigned SRAM_LATENCY = 1;
    localparam int unsigned MATRIX_SIZE  = 8;

    // SRAM read, input skew (size-1), array traversal (size), output register.
    function automatic int unsigned pipe_latency(input int unsigned matrix_size);
        return SRAM_LATENCY + (matrix_size - 1) + matrix_size + 1;
    endfunction

    localparam int unsigned DEFAULT_PIPE_LAT = pipe_latency(MATRIX_SIZE);

endpackage

// File: rtl/latency_tracker.sv
// Delays each issued UB read by the datapath latency to flag valid result rows,
// numbering them 0..N-1 within a pass.
module latency_tracker #(
    parameter int unsigned PIPE_LAT = 17,
    parameter int unsigned COUNT_BW = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                addr_valid,
    input  logic                clear,
    output logic                result_valid,
    output logic [COUNT_BW-1:0] result_index,
    output logic                last
);

    logic [PIPE_LAT-1:0] delay_line;
    logic [COUNT_BW-1:0] row_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            delay_line   <= '0;
            row_count    <= '0;
            result_index <= '0;
        end else if (clear) begin
            delay_line <= '0;
            row_count  <= '0;
        end else begin
            delay_line <= {delay_line[PIPE_LAT-2:0], addr_valid};
            // Index is loaded one cycle early so it lines up with result_valid.
            if (delay_line[PIPE_LAT-2]) begin
                result_index <= row_count;
                row_count    <= row_count + COUNT_BW'(1);
            end
        end
    end

    assign result_valid = delay_line[PIPE_LAT-1];
    assign last         = result_valid & ~(|delay_line[PIPE_LAT-2:0]) & ~addr_valid;

endmodule

// File: rtl/tpu_matmul_sequencer.sv
// Weight-stationary matmul pass sequencer: pops a weight tile, reloads the
// array, streams N UB addresses and flags result rows until completion.
module tpu_matmul_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE = 10,
    parameter int unsigned COUNT_BW    = 8,
    parameter int unsigned PIPE_LAT    = DEFAULT_PIPE_LAT
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [COUNT_BW-1:0]    num_vectors,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   we_rl,
    output logic [ADDRESSSIZE-1:0] sram_address,
    output logic                   addr_valid,
    output logic                   result_valid,
    output logic [COUNT_BW-1:0]    result_index,
    output logic                   busy,
    output logic                   done
);

    state_t                 state;
    state_t                 next_state;
    logic [ADDRESSSIZE-1:0] base_q;
    logic [COUNT_BW-1:0]    count_q;
    logic [COUNT_BW-1:0]    issue_cnt;
    logic                   accept;
    logic                   clear;
    logic                   last_issue;
    logic                   last_result;

    assign accept     = (state == S_IDLE) && start && !abort;
    assign clear      = abort || accept;
    assign last_issue = (issue_cnt + COUNT_BW'(1)) == count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (num_vectors == '0) ? S_DONE : S_WAIT_W;
            S_WAIT_W: if (!fifo_empty) next_state = S_LOAD_W;
            S_LOAD_W: next_state = S_RELOAD;
            S_RELOAD: next_state = S_STREAM;
            S_STREAM: if (last_issue) next_state = S_DRAIN;
            S_DRAIN:  if (last_result) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    // Outputs are registered from next_state so they align with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q           <= '0;
            count_q          <= '0;
            issue_cnt        <= '0;
            sram_address     <= '0;
            addr_valid       <= 1'b0;
            fifo_read_enable <= 1'b0;
            we_rl            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            if (accept) begin
                base_q  <= base_addr;
                count_q <= num_vectors;
            end
            issue_cnt <= (state == S_STREAM) ? issue_cnt + COUNT_BW'(1) : '0;
            if (next_state == S_STREAM) begin
                sram_address <= (state == S_STREAM) ? sram_address + ADDRESSSIZE'(1) : base_q;
            end
            addr_valid       <= (next_state == S_STREAM);
            fifo_read_enable <= (next_state == S_LOAD_W);
            we_rl            <= (next_state == S_RELOAD);
            busy             <= (next_state != S_IDLE);
            done             <= (next_state == S_DONE);
        end
    end

    latency_tracker #(
        .PIPE_LAT (PIPE_LAT),
        .COUNT_BW (COUNT_BW)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .addr_valid   (addr_valid),
        .clear        (clear),
        .result_valid (result_valid),
        .result_index (result_index),
        .last         (last_result)
    );

endmodule

// File: tb/tb_tpu_matmul_sequencer.sv
// Directed bench for tpu_matmul_sequencer: cycle-relative event logging per pass
// compared against hand-derived timing.
module tb_tpu_matmul_sequencer;

    localparam int AW = 10;
    localparam int CW = 8;
    localparam int PL = 17;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          fifo_empty = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_vectors = '0;
    logic          fifo_read_enable;
    logic          we_rl;
    logic [AW-1:0] sram_address;
    logic          addr_valid;
    logic          result_valid;
    logic [CW-1:0] result_index;
    logic          busy;
    logic          done;

    int tests = 0;
    int errors = 0;

    int p_base, p_n, p_fe, p_abort, p_start2, p_rst;
    int fre_first, fre_n, we_first, we_n, av_first, av_last, av_n;
    int rv_first, rv_n, done_first, done_n, busy_first, busy_last, busy_n, ovl_n;
    int addr_log [64];
    int idx_log  [64];

    tpu_matmul_sequencer #(
        .ADDRESSSIZE (AW),
        .COUNT_BW    (CW),
        .PIPE_LAT    (PL)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .abort            (abort),
        .base_addr        (base_addr),
        .num_vectors      (num_vectors),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .we_rl            (we_rl),
        .sram_address     (sram_address),
        .addr_valid       (addr_valid),
        .result_valid     (result_valid),
        .result_index     (result_index),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fre"},   int'(fifo_read_enable), 0);
        check({tag, " we_rl"}, int'(we_rl), 0);
        check({tag, " addr"},  int'(sram_address), 0);
        check({tag, " av"},    int'(addr_valid), 0);
        check({tag, " rv"},    int'(result_valid), 0);
        check({tag, " idx"},   int'(result_index), 0);
        check({tag, " busy"},  int'(busy), 0);
        check({tag, " done"},  int'(done), 0);
    endtask

    task automatic sched(input int b, input int n, input int fe, input int ab, input int s2, input int rs);
        p_base = b; p_n = n; p_fe = fe; p_abort = ab; p_start2 = s2; p_rst = rs;
    endtask

    task automatic drive(input int k);
        start      = (k == 0) || (k == p_start2);
        abort      = (k == p_abort);
        fifo_empty = (k < p_fe);
        if (k == 0) begin
            base_addr   = AW'(p_base);
            num_vectors = CW'(p_n);
        end else if (k == p_start2) begin
            base_addr   = 10'd500;
            num_vectors = 8'd7;
        end
        if (k == p_rst + 1) rstn = 1'b1;
    endtask

    task automatic sample(input int k);
        if (fifo_read_enable) begin
            if (fre_n == 0) fre_first = k;
            fre_n++;
        end
        if (we_rl) begin
            if (we_n == 0) we_first = k;
            we_n++;
        end
        if (addr_valid) begin
            if (av_n == 0) av_first = k;
            av_last = k;
            if (av_n < 64) addr_log[av_n] = int'(sram_address);
            av_n++;
        end
        if (result_valid) begin
            if (rv_n == 0) rv_first = k;
            if (rv_n < 64) idx_log[rv_n] = int'(result_index);
            rv_n++;
        end
        if (addr_valid && result_valid) ovl_n++;
        if (done) begin
            if (done_n == 0) done_first = k;
            done_n++;
        end
        if (busy) begin
            if (busy_n == 0) busy_first = k;
            busy_last = k;
            busy_n++;
        end
    endtask

    task automatic run_pass(input int cycles);
        fre_first = -1; fre_n = 0; we_first = -1; we_n = 0;
        av_first = -1; av_last = -1; av_n = 0; rv_first = -1; rv_n = 0;
        done_first = -1; done_n = 0; busy_first = -1; busy_last = -1; busy_n = 0; ovl_n = 0;
        @(posedge clk);
        #1 drive(0);
        for (int k = 0; k < cycles; k++) begin
            if (k == p_rst) begin
                #2 rstn = 1'b0;
                #1 check_all_zero("async_rst");
            end
            @(negedge clk);
            sample(k);
            @(posedge clk);
            #1 drive(k + 1);
        end
    endtask

    // d is the number of extra cycles spent waiting for a weight tile.
    task automatic verify_pass(input string tag, input int b, input int n, input int d);
        int done_at;
        done_at = 4 + d + n + PL;
        check({tag, " fre_at"},  fre_first, 2 + d);
        check({tag, " fre_n"},   fre_n, 1);
        check({tag, " we_at"},   we_first, 3 + d);
        check({tag, " we_n"},    we_n, 1);
        check({tag, " av_at"},   av_first, 4 + d);
        check({tag, " av_n"},    av_n, n);
        check({tag, " rv_at"},   rv_first, 4 + d + PL);
        check({tag, " rv_n"},    rv_n, n);
        check({tag, " done_at"}, done_first, done_at);
        check({tag, " done_n"},  done_n, 1);
        check({tag, " busy_at"}, busy_first, 1);
        check({tag, " busy_end"}, busy_last, done_at);
        check({tag, " busy_n"},  busy_n, done_at);
        for (int i = 0; i < n && i < 64; i++) begin
            check($sformatf("%s addr%0d", tag, i), addr_log[i], (b + i) % 1024);
            check($sformatf("%s idx%0d", tag, i), idx_log[i], i);
        end
    endtask

    initial begin
        #12 check_all_zero("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        sched(16, 4, 0, -1, -1, -1);
        run_pass(30);
        verify_pass("basic", 16, 4, 0);
        check("basic idx_hold", int'(result_index), 3);

        sched(100, 4, 11, -1, -1, -1);
        run_pass(40);
        verify_pass("fifo_wait", 100, 4, 10);

        sched(33, 0, 0, -1, -1, -1);
        run_pass(5);
        check("n0 done_at", done_first, 1);
        check("n0 done_n", done_n, 1);
        check("n0 busy_at", busy_first, 1);
        check("n0 busy_n", busy_n, 1);
        check("n0 fre_n", fre_n, 0);
        check("n0 we_n", we_n, 0);
        check("n0 av_n", av_n, 0);

        sched(1022, 4, 0, -1, -1, -1);
        run_pass(30);
        verify_pass("wrap", 1022, 4, 0);

        sched(200, 20, 0, -1, -1, -1);
        run_pass(46);
        verify_pass("long", 200, 20, 0);
        check("long overlap", ovl_n, 3);

        sched(40, 4, 0, 6, -1, -1);
        run_pass(30);
        check("abort av_n", av_n, 3);
        check("abort av_last", av_last, 6);
        check("abort rv_n", rv_n, 0);
        check("abort done_n", done_n, 0);
        check("abort busy_end", busy_last, 6);

        sched(60, 4, 0, -1, -1, -1);
        run_pass(30);
        verify_pass("after_abort", 60, 4, 0);

        sched(16, 4, 0, -1, -1, 10);
        run_pass(30);
        check("rst done_n", done_n, 0);
        check("rst rv_n", rv_n, 0);
        check("rst av_n", av_n, 4);
        check("rst busy_end", busy_last, 9);

        sched(16, 4, 0, -1, 5, -1);
        run_pass(30);
        verify_pass("restart_ignored", 16, 4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
